// File: rtl/frame_selector_ni.sv
// N-input frame multiplexer: switches source only between frames and
// forwards through a registered 2-entry skid buffer.
module frame_selector_ni #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_INPUTS     = 4,
    parameter int SEL_WIDTH      = 2,
    parameter int FLUSH_INACTIVE = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic [NUM_INPUTS-1:0]            in_frm_val,
    output logic [NUM_INPUTS-1:0]            in_frm_rdy,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_frm_data,
    input  logic [NUM_INPUTS-1:0]            in_frm_sof,
    input  logic [NUM_INPUTS-1:0]            in_frm_eof,
    input  logic [NUM_INPUTS-1:0]            in_frm_sol,
    input  logic [NUM_INPUTS-1:0]            in_frm_eol,
    output logic                             out_frm_val,
    input  logic                             out_frm_rdy,
    output logic [DATA_WIDTH-1:0]            out_frm_data,
    output logic                             out_frm_sof,
    output logic                             out_frm_eof,
    output logic                             out_frm_sol,
    output logic                             out_frm_eol,
    output logic [SEL_WIDTH-1:0]             act_ch,
    output logic                             frm_busy
);

    localparam int BW = DATA_WIDTH + 4;
    localparam logic [SEL_WIDTH:0] NUM_LIM = (SEL_WIDTH+1)'(NUM_INPUTS);

    typedef enum logic {
        IDLE,
        IN_FRAME
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SEL_WIDTH-1:0] act_nxt;
    logic                 rdy_en;
    logic                 skid_full;
    logic                 o_val;
    logic [BW-1:0]        o_q;
    logic [BW-1:0]        s_q;

    logic                  a_val;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_sof;
    logic                  a_eof;
    logic                  a_sol;
    logic                  a_eol;
    logic [BW-1:0]         a_beat;
    logic                  accept;
    logic                  sel_ok;

    assign sel_ok = {1'b0, sel} < NUM_LIM;

    always_comb begin
        a_val  = 1'b0;
        a_data = '0;
        a_sof  = 1'b0;
        a_eof  = 1'b0;
        a_sol  = 1'b0;
        a_eol  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (act_ch == SEL_WIDTH'(i)) begin
                a_val  = in_frm_val[i];
                a_data = in_frm_data[i*DATA_WIDTH +: DATA_WIDTH];
                a_sof  = in_frm_sof[i];
                a_eof  = in_frm_eof[i];
                a_sol  = in_frm_sol[i];
                a_eol  = in_frm_eol[i];
            end
        end
    end

    assign a_beat = {a_data, a_sof, a_eof, a_sol, a_eol};
    assign accept = a_val & rdy_en & ~skid_full;

    // Ready depends only on registers, never on val or out_frm_rdy.
    always_comb begin
        in_frm_rdy = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (act_ch == SEL_WIDTH'(i))
                in_frm_rdy[i] = rdy_en & ~skid_full;
            else
                in_frm_rdy[i] = (FLUSH_INACTIVE != 0) ? rdy_en : 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        act_nxt   = act_ch;
        unique case (state)
            IDLE: begin
                if (accept & a_sof & ~a_eof)
                    state_nxt = IN_FRAME;
                else if (sel_ok)
                    act_nxt = sel;
            end
            IN_FRAME: begin
                if (accept & a_eof) begin
                    state_nxt = IDLE;
                    if (sel_ok)
                        act_nxt = sel;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            act_ch <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            act_ch <= act_nxt;
            rdy_en <= 1'b1;
        end
    end

    // S only fills while O is stalled, so S full implies O full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_val     <= 1'b0;
            o_q       <= '0;
            s_q       <= '0;
            skid_full <= 1'b0;
        end else begin
            if (skid_full && out_frm_rdy) begin
                o_q       <= s_q;
                o_val     <= 1'b1;
                skid_full <= 1'b0;
            end else if (accept && (!o_val || out_frm_rdy)) begin
                o_q   <= a_beat;
                o_val <= 1'b1;
            end else if (accept) begin
                s_q       <= a_beat;
                skid_full <= 1'b1;
            end else if (o_val && out_frm_rdy) begin
                o_val <= 1'b0;
            end
        end
    end

    assign out_frm_val  = o_val;
    assign out_frm_data = o_q[BW-1:4];
    assign out_frm_sof  = o_q[3];
    assign out_frm_eof  = o_q[2];
    assign out_frm_sol  = o_q[1];
    assign out_frm_eol  = o_q[0];
    assign frm_busy     = (state == IN_FRAME);

endmodule

// File: tb/tb_frame_selector_ni.sv
// Bench for frame_selector_ni: directed scenarios, then random frames
// checked against a per-beat FIFO scoreboard with frame-integrity rules.
module tb_frame_selector_ni;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       sol;
        logic       eol;
    } beat_t;

    typedef struct packed {
        logic [1:0] ch;
        beat_t      b;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sel;
    logic [3:0]  in_val, in_rdy, in_sof, in_eof, in_sol, in_eol;
    logic [31:0] in_data;
    logic        out_val, out_rdy, out_sof, out_eof, out_sol, out_eol;
    logic [7:0]  out_data;
    logic [1:0]  act_ch;
    logic        frm_busy;

    logic [1:0]  sel2;
    logic [2:0]  val2, rdy2, sof2, eof2, sol2, eol2;
    logic [23:0] data2;
    logic        out2_val, out2_rdy, out2_sof, out2_eof, out2_sol, out2_eol;
    logic [7:0]  out2_data;
    logic [1:0]  act2;
    logic        busy2;

    frame_selector_ni #(
        .DATA_WIDTH(8), .NUM_INPUTS(4), .SEL_WIDTH(2), .FLUSH_INACTIVE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .in_frm_val(in_val), .in_frm_rdy(in_rdy), .in_frm_data(in_data),
        .in_frm_sof(in_sof), .in_frm_eof(in_eof),
        .in_frm_sol(in_sol), .in_frm_eol(in_eol),
        .out_frm_val(out_val), .out_frm_rdy(out_rdy),
        .out_frm_data(out_data),
        .out_frm_sof(out_sof), .out_frm_eof(out_eof),
        .out_frm_sol(out_sol), .out_frm_eol(out_eol),
        .act_ch(act_ch), .frm_busy(frm_busy)
    );

    frame_selector_ni #(
        .DATA_WIDTH(8), .NUM_INPUTS(3), .SEL_WIDTH(2), .FLUSH_INACTIVE(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel2),
        .in_frm_val(val2), .in_frm_rdy(rdy2), .in_frm_data(data2),
        .in_frm_sof(sof2), .in_frm_eof(eof2),
        .in_frm_sol(sol2), .in_frm_eol(eol2),
        .out_frm_val(out2_val), .out_frm_rdy(out2_rdy),
        .out_frm_data(out2_data),
        .out_frm_sof(out2_sof), .out_frm_eof(out2_eof),
        .out_frm_sol(out2_sol), .out_frm_eol(out2_eol),
        .act_ch(act2), .frm_busy(busy2)
    );

    beat_t stream[4][0:2047];
    int    len[4];
    int    ptr[4];
    logic  ven[4];
    logic  stopping;
    ent_t  exp_q[$];
    logic  in_frm;
    logic [1:0] cur_ch;
    logic  hold_v;
    beat_t hold_b;
    int    out_frames;
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_frame(input int c, input int n, input int w,
                             input logic [7:0] d0);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = d0 + 8'(k);
            b.sof  = (k == 0);
            b.eof  = (k == n - 1);
            b.sol  = (k % w == 0);
            b.eol  = (k % w == w - 1) || (k == n - 1);
            stream[c][len[c]] = b;
            len[c]++;
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int c = 0; c < 4; c++) begin
            b = (ptr[c] < len[c]) ? stream[c][ptr[c]] : '0;
            in_val[c] = ven[c] && (ptr[c] < len[c]) && !(stopping && b.sof);
            in_data[c*8 +: 8] = b.data;
            in_sof[c] = b.sof;
            in_eof[c] = b.eof;
            in_sol[c] = b.sol;
            in_eol[c] = b.eol;
        end
    endtask

    // Observe one cycle before its edge, then present the next inputs.
    task automatic tick();
        beat_t ob;
        ent_t  e;
        logic  has;
        int    fires;
        @(negedge clk);
        ob = {out_data, out_sof, out_eof, out_sol, out_eol};
        if (hold_v)
            chk("hold_payload", 32'(ob), 32'(hold_b));
        hold_v = out_val && !out_rdy;
        hold_b = ob;
        if (out_val && out_rdy) begin
            has = (exp_q.size() != 0);
            e = has ? exp_q.pop_front() : '0;
            chk("out_beat", 32'({has, ob}), 32'({1'b1, e.b}));
            if (ob.eof)
                out_frames++;
        end
        fires = 0;
        for (int c = 0; c < 4; c++) begin
            if (in_val[c] && in_rdy[c]) begin
                fires++;
                e.ch = 2'(c);
                e.b = stream[c][ptr[c]];
                if (in_frm)
                    chk("splice", 32'(c), 32'(cur_ch));
                else
                    chk("stray_start", 32'(e.b.sof), 1);
                if (!in_frm)
                    cur_ch = 2'(c);
                in_frm = !e.b.eof;
                exp_q.push_back(e);
                ptr[c]++;
            end
        end
        if (fires > 0)
            chk("multi_accept", 32'(fires > 1), 0);
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        int n;
        int p0;
        int base;
        sel = 2'd0; in_val = '0; in_data = '0; in_sof = '0; in_eof = '0;
        in_sol = '0; in_eol = '0; out_rdy = 1'b1;
        sel2 = 2'd0; val2 = '0; data2 = '0; sof2 = '0; eof2 = '0;
        sol2 = '0; eol2 = '0; out2_rdy = 1'b1;
        stopping = 1'b0; in_frm = 1'b0; cur_ch = '0; hold_v = 1'b0;
        hold_b = '0; out_frames = 0;
        for (int c = 0; c < 4; c++) begin
            len[c] = 0; ptr[c] = 0; ven[c] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_flags", 32'({out_sof, out_eof, out_sol, out_eol}), 0);
        chk("rst_act", 32'(act_ch), 0);
        chk("rst_busy", 32'(frm_busy), 0);
        chk("rst_rdy", 32'(in_rdy), 0);
        chk("rst_rdy2", 32'(rdy2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(in_rdy), 0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 32'(in_rdy), 32'h1);
        chk("rdy2_flush", 32'(rdy2), 32'h7);

        // Flush DUT: ch2 streams while ch0 active; single-beat frame on ch0.
        val2 = 3'b101; data2 = 24'hCC0055; sof2 = 3'b101; eof2 = 3'b101;
        @(posedge clk);
        #1;
        chk("single_out_val", 32'(out2_val), 1);
        chk("single_out_data", 32'(out2_data), 32'h55);
        chk("single_sof_eof", 32'({out2_sof, out2_eof}), 32'h3);
        chk("single_busy", 32'(busy2), 0);
        chk("flush_rdy", 32'(rdy2[2]), 1);
        val2[0] = 1'b0;
        sel2 = 2'd1;
        @(posedge clk);
        #1;
        chk("single_act_next", 32'(act2), 1);
        chk("single_busy2", 32'(busy2), 0);
        chk("flush_no_out", 32'(out2_val), 0);
        sel2 = 2'd3;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("illegal_sel_hold", 32'(act2), 1);
            chk("flush_no_out2", 32'(out2_val), 0);
        end
        chk("flush_rdy_all", 32'(rdy2), 32'h7);
        val2 = '0;

        // Frame-safe switch: sel 0->2 during an 8-beat ch0 frame.
        add_frame(0, 8, 4, 8'h00);
        add_frame(2, 2, 2, 8'hA0);
        add_frame(1, 16, 8, 8'h10);
        ven[0] = 1'b1;
        ven[2] = 1'b1;
        drive();
        n = 0;
        while (ptr[0] < 8 && n < 50) begin
            tick();
            n++;
            if (ptr[0] == 3)
                sel = 2'd2;
            if (ptr[0] < 8)
                chk("frame_act_frozen", 32'(act_ch), 0);
            if (ptr[0] >= 1 && ptr[0] < 8)
                chk("frame_busy", 32'(frm_busy), 1);
        end
        chk("frame0_sent", 32'(ptr[0]), 8);
        chk("act_after_eof", 32'(act_ch), 2);
        chk("busy_after_eof", 32'(frm_busy), 0);
        n = 0;
        while ((ptr[2] < 2 || exp_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("ch2_sent", 32'(ptr[2]), 2);
        chk("switch_drained", 32'(exp_q.size()), 0);

        // Back-pressure on a continuous ch1 stream.
        ven[2] = 1'b0;
        ven[0] = 1'b0;
        sel = 2'd1;
        ven[1] = 1'b1;
        n = 0;
        while (ptr[1] < 1 && n < 20) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("throughput", 32'(ptr[1]), 5);
        p0 = ptr[1];
        out_rdy = 1'b0;
        repeat (3) tick();
        chk("bp_one_extra", 32'(ptr[1] - p0), 1);
        chk("bp_rdy_low", 32'(in_rdy[1]), 0);
        out_rdy = 1'b1;
        n = 0;
        while ((ptr[1] < 16 || exp_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk("bp_all_sent", 32'(ptr[1]), 16);
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Reset in the middle of a 16-beat ch0 frame with S full.
        ven[1] = 1'b0;
        sel = 2'd0;
        n = 0;
        while (act_ch !== 2'd0 && n < 10) begin
            tick();
            n++;
        end
        chk("rst_test_act", 32'(act_ch), 0);
        base = len[0];
        add_frame(0, 16, 8, 8'h40);
        ven[0] = 1'b1;
        drive();
        n = 0;
        while (ptr[0] < base + 5 && n < 30) begin
            tick();
            n++;
        end
        out_rdy = 1'b0;
        tick();
        chk("skid_full_rdy", 32'(in_rdy[0]), 0);
        chk("skid_full_busy", 32'(frm_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", 32'(out_val), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_busy", 32'(frm_busy), 0);
        chk("mid_rst_act", 32'(act_ch), 0);
        chk("mid_rst_rdy", 32'(in_rdy), 0);
        exp_q.delete();
        in_frm = 1'b0;
        hold_v = 1'b0;
        ptr[0] = len[0];
        for (int c = 0; c < 4; c++)
            ven[c] = 1'b0;
        out_rdy = 1'b1;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_rdy", 32'(in_rdy), 0);
        @(posedge clk);
        #1;
        chk("release_rdy_rise", 32'(in_rdy), 32'h1);

        // Random frames on all channels with random sel and back-pressure.
        for (int c = 0; c < 4; c++)
            for (int f = 0; f < 200; f++)
                add_frame(c, int'($urandom_range(1, 8)), 2, 8'($urandom));
        out_frames = 0;
        n = 0;
        while (out_frames < 200 && n < 40000) begin
            for (int c = 0; c < 4; c++)
                ven[c] = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0)
                sel = 2'($urandom_range(0, 3));
            tick();
            n++;
        end
        chk("rand_frames", 32'(out_frames >= 200), 1);
        stopping = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 4; c++)
            ven[c] = 1'b1;
        repeat (40) tick();
        chk("rand_drained", 32'(exp_q.size()), 0);
        chk("rand_frame_closed", 32'(in_frm), 0);
        chk("rand_idle", 32'(frm_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_selector_ni.md
# frame_selector_ni

Registered N-input frame multiplexer for the IR filter pipeline: it selects one of `NUM_INPUTS` frame-interface sources and forwards it to a single frame-interface sink. The source only changes at frame boundaries, so a frame is never cut or spliced. A 2-entry output skid buffer registers all outputs and sustains full throughput. It sits between parallel filter chains (raw / filtered / overlay) and the display/DMA sink.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel data width.
- `NUM_INPUTS`, 4, number of input channels; legal range 2..16.
- `SEL_WIDTH`, 2, width of `sel`; `2**SEL_WIDTH >= NUM_INPUTS`.
- `FLUSH_INACTIVE`, 0
  - 0: inactive inputs are back-pressured (`rdy` = 0).
  - 1: inactive inputs are drained (`rdy` = 1) and their beats are discarded.

Ports (input channel `i` occupies bit `i`, or bits `[i*DATA_WIDTH +: DATA_WIDTH]` for data):
- `clk` in 1: system clock; one clock domain; all logic on the rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `sel` in `SEL_WIDTH`: requested channel. It is applied only at frame boundaries. Values `>= NUM_INPUTS` are ignored.
- `in_frm_val` in `NUM_INPUTS`: per-channel valid.
- `in_frm_rdy` out `NUM_INPUTS`: per-channel ready.
- `in_frm_data` in `NUM_INPUTS*DATA_WIDTH`: per-channel data.
- `in_frm_sof`, `in_frm_eof`, `in_frm_sol`, `in_frm_eol` in `NUM_INPUTS` each: per-channel framing flags.
- `out_frm_val` out 1, `out_frm_rdy` in 1, `out_frm_data` out `DATA_WIDTH`: output handshake and data.
- `out_frm_sof`, `out_frm_eof`, `out_frm_sol`, `out_frm_eol` out 1 each: output framing flags.
- `act_ch` out `SEL_WIDTH`: channel currently connected.
- `frm_busy` out 1: high while a multi-beat frame is in progress on `act_ch`.

## Operation
- **Beat acceptance.** A beat is accepted on channel `i` when `in_frm_val[i] & in_frm_rdy[i]`. Only channel `act_ch` is ever forwarded.
- **Ready generation.**
  - `rdy_en` is a register: reset 0, set to 1 on the first clock after reset release.
  - Active channel: `in_frm_rdy[act_ch] = rdy_en & ~skid_full`.
  - Inactive channels: `in_frm_rdy[i] = FLUSH_INACTIVE ? rdy_en : 0`.
- **State machine** (state `IDLE` / `IN_FRAME`; `frm_busy` = `state == IN_FRAME`):
  - `IDLE`:
    - Each cycle, if `sel < NUM_INPUTS` then `act_ch <= sel`, else `act_ch` holds.
    - Exception: an active-channel beat with `sof=1, eof=0` is accepted. Then go to `IN_FRAME` and hold `act_ch`.
    - A beat with `sof=1, eof=1` (single-beat frame) stays in `IDLE`.
    - A stray beat with `sof=0` is forwarded and the state stays `IDLE`.
  - `IN_FRAME`:
    - `act_ch` is frozen and `sel` is ignored.
    - An accepted beat with `eof=1` returns the FSM to `IDLE`, and `act_ch <= sel` (if legal) in that same cycle.
    - An accepted beat with `sof=1` is forwarded unchanged and the FSM stays in `IN_FRAME`.
- **Skid buffer** (output register O plus skid register S, each holding data and the 4 flags):
  - Accepted beat, and (O empty or `out_frm_rdy`): load O.
  - Accepted beat, O full and `~out_frm_rdy`: load S (`skid_full` <= 1).
  - S full and `out_frm_rdy`: O <= S, S empties. No beat can be accepted that cycle, because `skid_full` gates ready.
  - O valid, `out_frm_rdy`, nothing accepted and S empty: O empties.
  - `out_frm_*` are driven directly from O. Payload is unchanged while `out_frm_val & ~out_frm_rdy`.
- **Reset mid-frame** aborts everything: FSM to `IDLE`, `act_ch` to 0, O and S emptied. Partial frames are not completed.

## Timing
- **Reset values:**
  - `out_frm_val`, `sof`, `eof`, `sol`, `eol` = 0; `out_frm_data` = 0.
  - `act_ch` = 0, `frm_busy` = 0, all `in_frm_rdy` = 0.
  - `rdy_en` = 0 until the first edge after reset deassertion.
- **Latency:** an accepted beat appears on `out_frm_*` on the next cycle.
- **Throughput:** 1 beat/cycle with `out_frm_rdy` held high.
- **Back-pressure:** after `out_frm_rdy` drops, at most one further beat is accepted, into S. Then the active `rdy` is 0.
- **Select latency:** a `sel` change in `IDLE` takes effect one cycle later, via `act_ch`. A beat accepted in the same cycle as the change belongs to the old `act_ch`.
- `in_frm_rdy` is combinational from registers only. It has no path from `in_frm_val` or `out_frm_rdy`.

## Test plan
- **Frame-safe switch:**
  - Stimulus: ch0 sends a 4x2 frame (8 beats). `sel` changes 0->2 at beat 3.
  - Required response: all 8 ch0 beats are output. `act_ch` = 2 in the cycle after the eof beat is accepted. The next output frame comes from ch2.
- **Back-pressure:**
  - Stimulus: continuous stream on ch1; `out_frm_rdy` low for 3 cycles mid-line.
  - Required response: exactly one extra beat is accepted, no beat is lost or duplicated, and data order is preserved (0x10,0x11,...).
- **Flush mode:**
  - Stimulus: `FLUSH_INACTIVE=1`, ch0 active, ch3 streaming.
  - Required response: `in_frm_rdy[3]` = 1 and no ch3 data is output. With `FLUSH_INACTIVE=0`, `in_frm_rdy[3]` = 0.
- **Illegal select and single-beat frame:**
  - Stimulus: `NUM_INPUTS=3`, `SEL_WIDTH=2`, `sel`=3.
    - Required response: `act_ch` holds.
  - Stimulus: a single-beat sof&eof frame on ch0, then `sel`=1.
    - Required response: `frm_busy` stays 0 and `act_ch` = 1 next cycle.
- **Reset mid-frame:**
  - Stimulus: assert `rst_n`=0 at beat 5 of a 16-beat frame, with S full.
  - Required response: immediately `out_frm_val`=0, `frm_busy`=0, `act_ch`=0 and all `rdy`=0. After release, `rdy` rises one cycle later.
- **Random throughput:**
  - Stimulus: 4 inputs with random val/rdy, random `sel`, 200 frames.
  - Required response: every output frame is complete and single-source, and output matches the scoreboard.
